// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit indices and FSM state types for uart_mmio.
// Build option: UART_PARITY_EN adds the PARITY states (8E1 frames).
package uart_pkg;
   localparam logic [31:0] TXD_OFF    = 32'h0;
   localparam logic [31:0] RXD_OFF    = 32'h4;
   localparam logic [31:0] STATUS_OFF = 32'h8;
   localparam logic [31:0] CTRL_OFF   = 32'hC;
   localparam int ST_RX_NEMPTY = 0;
   localparam int ST_RX_FULL   = 1;
   localparam int ST_TX_FULL   = 2;
   localparam int ST_TX_IDLE   = 3;
   localparam int ST_OVERRUN   = 4;
   localparam int ST_FRAMING   = 5;
   localparam int ST_PARITY    = 6;
`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif
endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO.
// Ports: clk, reset (sync, active-high); push/din write; pop reads dout (head);
// full, empty, count status. Push on full is accepted only with a simultaneous pop;
// pop on empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | pop);
   assign dout    = mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clk) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= do_push ? wp + 1'b1 : wp;
         rp    <= do_pop ? rp + 1'b1 : rp;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped full-duplex UART with baud divisor, RX/TX FIFOs,
// sticky error flags and maskable level interrupt.
// Ports: clk, reset (sync, active-high); rd/wr/addr/wdata/rdata peripheral bus;
// irqout level interrupt; UART_RX async serial in; UART_TX serial out (idle high).
// Build option: UART_PARITY_EN selects 8E1 frames instead of 8N1.
module uart_mmio
   import uart_pkg::*;
#(
   parameter int          BAUD_DIV   = 5208,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h40000018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout,
   input  logic        UART_RX,
   output logic        UART_TX
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF   = CW'(BAUD_DIV / 2 - 1);

   logic sel_txd, sel_rxd, sel_status, sel_ctrl, w1c;
   logic [1:0] ctrl;
   logic ovr, fe, pe;
   logic [6:0] status;
   logic unused_bits;
   assign sel_txd    = addr == BASE_ADDR + TXD_OFF;
   assign sel_rxd    = addr == BASE_ADDR + RXD_OFF;
   assign sel_status = addr == BASE_ADDR + STATUS_OFF;
   assign sel_ctrl   = addr == BASE_ADDR + CTRL_OFF;
   assign w1c        = wr & sel_status;
   assign unused_bits = ^wdata[31:8];

   logic rx_push, rx_pop, rx_full, rx_empty;
   logic tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0] rx_dout, tx_dout, rx_sh, tx_sh;
   logic [FW:0] rx_count, tx_count;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_sh),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count));

   // ---------------- RX ----------------
   rx_state_t rx_state;
   logic rx_s1, rx_s2, rx_s3, rx_tick, rx_ok, ovr_evt, fe_evt, pe_evt;
   logic [CW-1:0] rx_cnt;
   logic [2:0] rx_idx;
   assign rx_tick = rx_cnt == '0;
   assign rx_push = rx_state == RX_STOP & rx_tick & rx_s2 & rx_ok;
   assign rx_pop  = rd & sel_rxd & ~rx_empty;
   // a full FIFO still accepts the byte when the same cycle pops one
   assign ovr_evt = rx_push & rx_full & ~rx_pop;
   assign fe_evt  = rx_state == RX_STOP & rx_tick & ~rx_s2;

   always_ff @(posedge clk) begin
      if (reset) {rx_s1, rx_s2, rx_s3} <= 3'b111;
      else {rx_s1, rx_s2, rx_s3} <= {UART_RX, rx_s1, rx_s2};
   end

`ifdef UART_PARITY_EN
   logic par_bad;
   assign pe_evt = rx_state == RX_PARITY & rx_tick & (rx_s2 != ^rx_sh);
   assign rx_ok  = ~par_bad;
   always_ff @(posedge clk) begin
      if (reset) par_bad <= 1'b0;
      else if (rx_state == RX_PARITY & rx_tick) par_bad <= pe_evt;
   end
`else
   assign pe_evt = 1'b0;
   assign rx_ok  = 1'b1;
`endif

   // IDLE preloads the half-bit count so START lands on the start-bit midpoint
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_cnt <= rx_state == RX_IDLE ? HALF : rx_tick ? RELOAD : rx_cnt - 1'b1;
         case (rx_state)
            RX_IDLE:      if (rx_s3 & ~rx_s2) rx_state <= RX_START;
            RX_START:     if (rx_tick) begin
                             rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                             rx_idx   <= '0;
                          end
            RX_DATA:      if (rx_tick) begin
                             rx_sh  <= {rx_s2, rx_sh[7:1]};
                             rx_idx <= rx_idx + 3'd1;
`ifdef UART_PARITY_EN
                             if (rx_idx == 3'd7) rx_state <= RX_PARITY;
`else
                             if (rx_idx == 3'd7) rx_state <= RX_STOP;
`endif
                          end
`ifdef UART_PARITY_EN
            RX_PARITY:    if (rx_tick) rx_state <= RX_STOP;
`endif
            RX_STOP:      if (rx_tick) rx_state <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s2) rx_state <= RX_IDLE;
            default:      rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------- TX ----------------
   tx_state_t tx_state;
   logic tx_tick, tx_q, tx_idle;
   logic [CW-1:0] tx_cnt;
   logic [2:0] tx_idx;
   assign tx_tick = tx_cnt == '0;
   assign tx_push = wr & sel_txd;
   // the next byte is fetched at the end of STOP so frames run back to back
   assign tx_pop  = ~tx_empty & (tx_state == TX_IDLE | (tx_state == TX_STOP & tx_tick));
   assign tx_idle = tx_count == '0 & tx_state == TX_IDLE;
   assign UART_TX = tx_q;

`ifdef UART_PARITY_EN
   logic tx_par;
   always_ff @(posedge clk) begin
      if (reset) tx_par <= 1'b0;
      else if (tx_pop) tx_par <= ^tx_dout;
   end
`endif

   // UART_TX is registered from the current state, so it trails the FSM by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_sh    <= '0;
         tx_q     <= 1'b1;
      end else begin
         tx_cnt <= (tx_state == TX_IDLE | tx_tick) ? RELOAD : tx_cnt - 1'b1;
         tx_q   <= tx_state == TX_START ? 1'b0 :
                   tx_state == TX_DATA  ? tx_sh[0] :
`ifdef UART_PARITY_EN
                   tx_state == TX_PARITY ? tx_par :
`endif
                   1'b1;
         if (tx_pop) tx_sh <= tx_dout;
         case (tx_state)
            TX_IDLE:   if (tx_pop) tx_state <= TX_START;
            TX_START:  if (tx_tick) begin
                          tx_state <= TX_DATA;
                          tx_idx   <= '0;
                       end
            TX_DATA:   if (tx_tick) begin
                          tx_sh  <= {1'b0, tx_sh[7:1]};
                          tx_idx <= tx_idx + 3'd1;
`ifdef UART_PARITY_EN
                          if (tx_idx == 3'd7) tx_state <= TX_PARITY;
`else
                          if (tx_idx == 3'd7) tx_state <= TX_STOP;
`endif
                       end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tx_tick) tx_state <= TX_STOP;
`endif
            TX_STOP:   if (tx_tick) tx_state <= tx_pop ? TX_START : TX_IDLE;
            default:   tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- registers ----------------
   // a new error event wins over a same-cycle write-1-to-clear
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl <= '0;
         ovr  <= 1'b0;
         fe   <= 1'b0;
         pe   <= 1'b0;
      end else begin
         ctrl <= wr & sel_ctrl ? wdata[1:0] : ctrl;
         ovr  <= ovr_evt | (ovr & ~(w1c & wdata[ST_OVERRUN]));
         fe   <= fe_evt | (fe & ~(w1c & wdata[ST_FRAMING]));
         pe   <= pe_evt | (pe & ~(w1c & wdata[ST_PARITY]));
      end
   end

   assign status = {pe, fe, ovr, tx_idle, tx_full, rx_full, rx_count != '0};
   assign irqout = (ctrl[0] & (status[ST_RX_NEMPTY] | ovr | fe | pe)) | (ctrl[1] & tx_idle);
   assign rdata  = !rd        ? 32'h0 :
                   sel_rxd    ? {24'h0, rx_empty ? 8'h00 : rx_dout} :
                   sel_status ? {25'h0, status} :
                   sel_ctrl   ? {30'h0, ctrl} : 32'h0;
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed self-checking bench for uart_mmio (BAUD_DIV=16, FIFO_DEPTH=4).
module tb_uart_mmio;
   import uart_pkg::*;
   localparam logic [31:0] BASE = 32'h40000018;
`ifdef UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, rx_line = 1'b1;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata, r;
   logic irqout, tx_line;
   int n_cmp = 0, n_err = 0;

   uart_mmio #(.BAUD_DIV(16), .FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irqout(irqout), .UART_RX(rx_line), .UART_TX(tx_line));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
      addr = BASE + off; wdata = d; wr = 1'b1;
      tick(1);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
      addr = BASE + off; rd = 1'b1;
      #1 d = rdata;
      tick(1);
      rd = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(off, v);
      check(tag, v, exp);
   endtask

   function automatic logic [10:0] frm(input logic [7:0] d, input logic stop);
`ifdef UART_PARITY_EN
      return {stop, ^d, d, 1'b0};
`else
      return {1'b0, stop, d, 1'b0};
`endif
   endfunction

   task automatic send_bits(input logic [10:0] b);
      for (int i = 0; i < NB; i++) begin
         rx_line = b[i];
         tick(16);
      end
      rx_line = 1'b1;
      tick(4);
   endtask

   // call immediately after the TXD write (edge N): line low from N+2, mid-bit samples
   task automatic tx_expect(input logic [7:0] d);
      logic [31:0] s;
      check("tx_n0", tx_line, 1);
      tick(1);
      check("tx_n1", tx_line, 1);
      tick(1);
      check("tx_start_edge", tx_line, 0);
      tick(8);
      check("tx_start_mid", tx_line, 0);
      for (int i = 0; i < 8; i++) begin
         tick(16);
         check($sformatf("tx_bit%0d", i), tx_line, d[i]);
      end
`ifdef UART_PARITY_EN
      tick(16);
      check("tx_parity", tx_line, ^d);
`endif
      tick(16);
      check("tx_stop", tx_line, 1);
      bus_read(STATUS_OFF, s);
      check("tx_busy_status", s & 32'h8, 0);
      tick(7);
      check("tx_after_line", tx_line, 1);
      check_reg("tx_idle_status", STATUS_OFF, 32'h08);
   endtask

   initial begin
      tick(2);
      check("rst_tx", tx_line, 1);
      check("rst_irq", irqout, 0);
      reset = 1'b0;
      addr = BASE + STATUS_OFF;
      #1 check("rd0_rdata", rdata, 0);
      check_reg("rst_status", STATUS_OFF, 32'h08);
      check_reg("rst_ctrl", CTRL_OFF, 32'h0);

      // reset in the middle of a transmitted frame
      bus_write(CTRL_OFF, 32'h2);
      check("irq_tx_idle", irqout, 1);
      bus_write(TXD_OFF, 32'h00);
      tick(40);
      check("midtx_low", tx_line, 0);
      check("midtx_irq", irqout, 0);
      reset = 1'b1;
      tick(1);
      check("midtx_rst_tx", tx_line, 1);
      reset = 1'b0;
      tick(1);
      check_reg("midtx_status", STATUS_OFF, 32'h08);
      check("midtx_irq_rst", irqout, 0);

      // single received byte
      send_bits(frm(8'h5A, 1'b1));
      check_reg("rx_status", STATUS_OFF, 32'h09);
      bus_write(CTRL_OFF, 32'h1);
      check("rx_irq", irqout, 1);
      check_reg("rx_data", RXD_OFF, 32'h5A);
      check_reg("rx_empty_read", RXD_OFF, 32'h0);
      check_reg("rx_status_empty", STATUS_OFF, 32'h08);
      check("rx_irq_clear", irqout, 0);

      // transmit 0xAC
      bus_write(TXD_OFF, 32'hAC);
      tx_expect(8'hAC);

      // overrun with 5 unread frames into a 4-deep FIFO
      for (int k = 1; k <= 5; k++) send_bits(frm(8'(k), 1'b1));
      check_reg("ovr_status", STATUS_OFF, 32'h1B);
      check("ovr_irq", irqout, 1);
      for (int k = 1; k <= 4; k++) check_reg($sformatf("ovr_rd%0d", k), RXD_OFF, 32'(k));
      check_reg("ovr_drained", STATUS_OFF, 32'h18);
      bus_write(STATUS_OFF, 32'h10);
      check_reg("ovr_cleared", STATUS_OFF, 32'h08);
      check("ovr_irq_clear", irqout, 0);

      // framing error then recovery
      send_bits(frm(8'h33, 1'b0));
      tick(4);
      check_reg("fe_status", STATUS_OFF, 32'h28);
      check("fe_irq", irqout, 1);
      send_bits(frm(8'h96, 1'b1));
      check_reg("fe_next_status", STATUS_OFF, 32'h29);
      check_reg("fe_next_data", RXD_OFF, 32'h96);
      bus_write(STATUS_OFF, 32'h20);
      check_reg("fe_cleared", STATUS_OFF, 32'h08);
      check("fe_irq_clear", irqout, 0);

`ifdef UART_PARITY_EN
      send_bits(11'b1_1_00000011_0);
      check_reg("pe_status", STATUS_OFF, 32'h48);
      bus_write(TXD_OFF, 32'h03);
      tx_expect(8'h03);
      bus_write(STATUS_OFF, 32'h40);
      check_reg("pe_cleared", STATUS_OFF, 32'h08);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Parametrised, memory-mapped full-duplex UART for the MIPS pipelined CPU peripheral bus. It replaces the fixed-rate, single-byte UART inside the peripheral block with a programmable baud divisor, RX and TX FIFOs, sticky error flags and maskable interrupts. It sits on the same rd/wr/addr/wdata/rdata bus as the LED, switch and digit registers, and drives one interrupt line into the CPU interrupt logic.

## Interface
- BAUD_DIV, 5208: clk cycles per bit (50 MHz / 9600); legal range 4..65535
- FIFO_DEPTH, 8: entries in each of the RX and TX FIFOs; power of two, 2..64
- BASE_ADDR, 32'h40000018: byte address of register 0
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- rd  in  1  bus read strobe
- wr  in  1  bus write strobe
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- rdata  out  32  read data; combinational from addr; 0 when no register matches or rd=0
- irqout  out  1  level interrupt
- UART_RX  in  1  serial input, asynchronous
- UART_TX  out  1  serial output, idle high

## Operation
- Register map, relative to BASE_ADDR:
  - +0 TXD (W): wdata[7:0] is pushed to the TX FIFO. A push while the FIFO is full is ignored.
  - +4 RXD (R): returns the RX FIFO head in [7:0]. An rd cycle pops it. Reading an empty FIFO returns 0 and does not pop.
  - +8 STATUS (R/W1C):
    - [0] rx_nempty
    - [1] rx_full
    - [2] tx_full
    - [3] tx_idle: TX FIFO empty and the TX engine is idle
    - [4] overrun, sticky
    - [5] framing error, sticky
    - [6] parity error, sticky
    - Writing 1 to bits [6:4] clears them.
  - +C CTRL (R/W): [0] rx_irq_en, [1] tx_irq_en.
- irqout = (CTRL[0] & (rx_nempty | STATUS[6:4]≠0)) | (CTRL[1] & tx_idle).
- Frame format: 8N1, LSB first. With UART_PARITY_EN defined, 8E1.
- UART_RX passes through a 2-flop synchroniser before any use.
- RX FSM:
  - States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE→START on a synchronised falling edge.
  - START re-samples the line at BAUD_DIV/2. If the line is high, return to IDLE (glitch).
  - Each remaining bit is sampled every BAUD_DIV cycles from that midpoint.
  - STOP sample = 1: the byte is pushed to the RX FIFO. If the FIFO is full, the byte is dropped and overrun is set.
  - STOP sample = 0: the byte is discarded, framing error is set, and the FSM goes to WAIT_HIGH until the line reads 1.
- TX FSM:
  - States: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, a non-empty FIFO is popped and START is entered.
  - Each bit lasts exactly BAUD_DIV cycles.
  - After STOP, the FSM pops the next byte and goes directly to START with no idle gap.
- Simultaneous push and pop on a full FIFO: both happen and the count is unchanged; no overrun.
- Simultaneous push and pop on an empty FIFO: the push happens; the pop is a no-op.
- Simultaneous W1C and a new error event on the same bit: the bit ends set.
- Reset mid-frame: both FSMs go to IDLE and both FIFOs are emptied. A partially received frame is lost. UART_TX returns high the next cycle.

## Timing
- Reset values: UART_TX=1, irqout=0, all FIFO pointers and counts 0, STATUS=0x08, CTRL=0, rdata=0.
- Register writes take effect at the clk edge on which wr is sampled.
- TX latency: with TX idle, a TXD write at edge N drives UART_TX low from edge N+2.
- RX latency: rx_nempty rises one cycle after the stop-bit midpoint sample. Add 2 cycles of synchroniser latency from the line edge.
- Frame length: 10·BAUD_DIV cycles without parity, 11·BAUD_DIV with UART_PARITY_EN.
- Bit counters are $clog2(BAUD_DIV) wide and reload to BAUD_DIV-1 on wrap.

## Configuration
- UART_PARITY_EN:
  - Defined: TX appends an even-parity bit after D7. RX checks it.
  - On a parity mismatch: the byte is discarded, STATUS[6] is set, and RX continues to STOP normally.
  - Undefined: no parity states exist, and STATUS[6] reads 0.

## Structure
- Package uart_pkg holds:
  - register offsets (TXD_OFF, RXD_OFF, STATUS_OFF, CTRL_OFF)
  - STATUS bit indices
  - rx_state_t and tx_state_t enums
- One sub-module, sync_fifo (WIDTH, DEPTH; push, pop, full, empty, count), instantiated once for RX and once for TX.
- Baud counters and FSMs stay in the top level.

## Test plan
All cases use BAUD_DIV=16, FIFO_DEPTH=4.
- Reset mid-TX-frame → UART_TX=1 the next cycle, STATUS reads 0x08, irqout=0.
- Drive an RX frame carrying 0x5A → STATUS[0]=1. A read of +4 returns 0x5A. Next read returns 0, STATUS[0]=0.
- Write 0xAC to +0 → UART_TX is low from edge N+2, then bits 0,0,1,1,0,1,0,1, then stop=1, 160 cycles total. STATUS[3] then returns to 1.
- Send 5 frames 0x01..0x05 unread → reads return 0x01..0x04, STATUS[4]=1. Writing 0x10 to +8 clears it.
- Send a frame with stop=0 → no push, STATUS[5]=1. With CTRL=1, irqout=1. Next valid frame is received correctly.
- UART_PARITY_EN, frame 0x03 with parity bit 1 → no push, STATUS[6]=1. TX of 0x03 sends parity bit 0.
